// File: rtl/snake_collision_engine.sv
// Snake move engine: computes the next head cell from head + direction and
// classifies the move as wall / body / food hit. Keeps a sticky game-over flag
// and a saturating food counter. Four-state sequencer, result at T+3.
module snake_collision_engine #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int XW     = 3,
    parameter int YW     = 3,
    parameter int WRAP   = 0,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    output logic                       ready,
    input  logic [XW-1:0]              head_x,
    input  logic [YW-1:0]              head_y,
    input  logic [1:0]                 dir,
    input  logic [XW-1:0]              tail_x,
    input  logic [YW-1:0]              tail_y,
    input  logic [XW-1:0]              food_x,
    input  logic [YW-1:0]              food_y,
    input  logic [GRID_W*GRID_H-1:0]   occupancy,
    input  logic                       clear_over,
    output logic                       done,
    output logic [XW-1:0]              next_x,
    output logic [YW-1:0]              next_y,
    output logic                       hit_wall,
    output logic                       hit_body,
    output logic                       hit_food,
    output logic                       collide,
    output logic                       game_over,
    output logic [CNT_W-1:0]           food_count
);

    typedef enum logic [1:0] {IDLE, STEP, CHECK, REPORT} state_t;

    // Grid bounds at coordinate width (+1 bit so GRID_W == 2**XW still fits).
    localparam logic [XW:0]   GW   = (XW+1)'(GRID_W);
    localparam logic [YW:0]   GH   = (YW+1)'(GRID_H);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

    state_t state_q, state_d;

    // Captured move request
    logic [XW-1:0]            hx_q, hx_d, tx_q, tx_d, fx_q, fx_d;
    logic [YW-1:0]            hy_q, hy_d, ty_q, ty_d, fy_q, fy_d;
    logic [1:0]               dir_q, dir_d;
    logic [GRID_W*GRID_H-1:0] occ_q, occ_d;

    // Candidate cell from STEP
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          wall_q, wall_d;

    // Result / status registers
    logic [XW-1:0]    nx_q, nx_d;
    logic [YW-1:0]    ny_q, ny_d;
    logic             hw_q, hw_d, hb_q, hb_d, hf_q, hf_d, done_q, done_d, go_q, go_d;
    logic [CNT_W-1:0] fc_q, fc_d;

    // Step stage signals
    logic [XW-1:0] step_x;
    logic [YW-1:0] step_y;
    logic          step_wall;

    // Check stage signals
    logic occ_bit, chk_food, chk_tail, chk_body;

    // Next cell and wall flag; a head already off-grid is always a wall hit.
    // Edges are compared explicitly so wrap works for any grid size.
    always_comb begin
        step_x    = hx_q;
        step_y    = hy_q;
        step_wall = 1'b0;
        if (({1'b0, hx_q} >= GW) || ({1'b0, hy_q} >= GH)) begin
            step_wall = 1'b1;
        end else begin
            case (dir_q)
                2'b00: if (hy_q == '0) begin
                           if (WRAP != 0) step_y = YMAX; else step_wall = 1'b1;
                       end else step_y = hy_q - YW'(1);
                2'b01: if (hy_q == YMAX) begin
                           if (WRAP != 0) step_y = '0; else step_wall = 1'b1;
                       end else step_y = hy_q + YW'(1);
                2'b10: if (hx_q == '0) begin
                           if (WRAP != 0) step_x = XMAX; else step_wall = 1'b1;
                       end else step_x = hx_q - XW'(1);
                default: if (hx_q == XMAX) begin
                           if (WRAP != 0) step_x = '0; else step_wall = 1'b1;
                       end else step_x = hx_q + XW'(1);
            endcase
        end
    end

    // Occupancy lookup at the candidate (x=0 is the row MSB) and hit flags.
    // The tail cell is vacated on a normal move but stays put when food is eaten.
    always_comb begin
        occ_bit = 1'b0;
        for (int yy = 0; yy < GRID_H; yy++) begin
            for (int xx = 0; xx < GRID_W; xx++) begin
                if (cy_q == YW'(yy) && cx_q == XW'(xx))
                    occ_bit = occ_q[yy*GRID_W + GRID_W - 1 - xx];
            end
        end
        chk_food = !wall_q && (cx_q == fx_q) && (cy_q == fy_q);
        chk_tail = (cx_q == tx_q) && (cy_q == ty_q);
        chk_body = !wall_q && occ_bit && !(chk_tail && !chk_food);
    end

    // Sequencer, request capture, result load and game status update
    always_comb begin
        state_d = state_q;
        hx_d = hx_q;  hy_d = hy_q;  dir_d = dir_q;
        tx_d = tx_q;  ty_d = ty_q;  fx_d = fx_q;  fy_d = fy_q;
        occ_d = occ_q;
        cx_d = cx_q;  cy_d = cy_q;  wall_d = wall_q;
        nx_d = nx_q;  ny_d = ny_q;
        hw_d = hw_q;  hb_d = hb_q;  hf_d = hf_q;
        done_d = 1'b0;
        go_d = go_q;
        fc_d = fc_q;

        case (state_q)
            IDLE: if (start && ready) begin
                hx_d = head_x;  hy_d = head_y;  dir_d = dir;
                tx_d = tail_x;  ty_d = tail_y;
                fx_d = food_x;  fy_d = food_y;
                occ_d = occupancy;
                state_d = STEP;
            end
            STEP: begin
                cx_d = step_x;  cy_d = step_y;  wall_d = step_wall;
                state_d = CHECK;
            end
            CHECK: begin
                nx_d = cx_q;  ny_d = cy_q;
                hw_d = wall_q;  hb_d = chk_body;  hf_d = chk_food;
                done_d = 1'b1;
                state_d = REPORT;
            end
            default: state_d = IDLE;
        endcase

        if (clear_over) begin
            go_d = 1'b0;
            fc_d = '0;
        end
        // A collision in REPORT overrides a simultaneous clear.
        if (state_q == REPORT) begin
            if (hw_q || hb_q)
                go_d = 1'b1;
            else if (hf_q && !clear_over && fc_q != {CNT_W{1'b1}})
                fc_d = fc_q + CNT_W'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hx_q <= '0;  hy_q <= '0;  dir_q <= '0;
            tx_q <= '0;  ty_q <= '0;  fx_q <= '0;  fy_q <= '0;
            occ_q <= '0;
            cx_q <= '0;  cy_q <= '0;  wall_q <= 1'b0;
            nx_q <= '0;  ny_q <= '0;
            hw_q <= 1'b0;  hb_q <= 1'b0;  hf_q <= 1'b0;
            done_q <= 1'b0;  go_q <= 1'b0;  fc_q <= '0;
        end else begin
            state_q <= state_d;
            hx_q <= hx_d;  hy_q <= hy_d;  dir_q <= dir_d;
            tx_q <= tx_d;  ty_q <= ty_d;  fx_q <= fx_d;  fy_q <= fy_d;
            occ_q <= occ_d;
            cx_q <= cx_d;  cy_q <= cy_d;  wall_q <= wall_d;
            nx_q <= nx_d;  ny_q <= ny_d;
            hw_q <= hw_d;  hb_q <= hb_d;  hf_q <= hf_d;
            done_q <= done_d;  go_q <= go_d;  fc_q <= fc_d;
        end
    end

    assign ready      = (state_q == IDLE) && !go_q;
    assign done       = done_q;
    assign next_x     = nx_q;
    assign next_y     = ny_q;
    assign hit_wall   = hw_q;
    assign hit_body   = hb_q;
    assign hit_food   = hf_q;
    assign collide    = hw_q | hb_q;
    assign game_over  = go_q;
    assign food_count = fc_q;

endmodule

// File: tb/tb_snake_collision_engine.sv
// Bench for snake_collision_engine: three instances (8x8 walls, 8x8 wrap,
// 5x6 wrap with a 2-bit food counter). Vector table + expected-result queue
// per instance, popped when done pulses; plus hand-written corner sequences.
module tb_snake_collision_engine;

    localparam logic [1:0] U = 2'd0, D = 2'd1, L = 2'd2, R = 2'd3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  st = '0, clr = '0;
    logic [2:0]  hx_i = '0, hy_i = '0, tx_i = '0, ty_i = '0, fx_i = '0, fy_i = '0;
    logic [1:0]  dir_i = '0;
    logic [63:0] occ_i = '0;
    logic [29:0] occ2_i = '0;

    logic [2:0] done_v, ready_v, hw_v, hb_v, hf_v, col_v, go_v;
    logic [2:0] nx_v [3];
    logic [2:0] ny_v [3];
    logic [7:0] fc0, fc1;
    logic [1:0] fc2;

    snake_collision_engine #(.GRID_W(8), .GRID_H(8), .XW(3), .YW(3), .WRAP(0), .CNT_W(8)) u0 (
        .clk(clk), .reset_n(reset_n), .start(st[0]), .ready(ready_v[0]),
        .head_x(hx_i), .head_y(hy_i), .dir(dir_i), .tail_x(tx_i), .tail_y(ty_i),
        .food_x(fx_i), .food_y(fy_i), .occupancy(occ_i), .clear_over(clr[0]),
        .done(done_v[0]), .next_x(nx_v[0]), .next_y(ny_v[0]), .hit_wall(hw_v[0]),
        .hit_body(hb_v[0]), .hit_food(hf_v[0]), .collide(col_v[0]),
        .game_over(go_v[0]), .food_count(fc0));

    snake_collision_engine #(.GRID_W(8), .GRID_H(8), .XW(3), .YW(3), .WRAP(1), .CNT_W(8)) u1 (
        .clk(clk), .reset_n(reset_n), .start(st[1]), .ready(ready_v[1]),
        .head_x(hx_i), .head_y(hy_i), .dir(dir_i), .tail_x(tx_i), .tail_y(ty_i),
        .food_x(fx_i), .food_y(fy_i), .occupancy(occ_i), .clear_over(clr[1]),
        .done(done_v[1]), .next_x(nx_v[1]), .next_y(ny_v[1]), .hit_wall(hw_v[1]),
        .hit_body(hb_v[1]), .hit_food(hf_v[1]), .collide(col_v[1]),
        .game_over(go_v[1]), .food_count(fc1));

    snake_collision_engine #(.GRID_W(5), .GRID_H(6), .XW(3), .YW(3), .WRAP(1), .CNT_W(2)) u2 (
        .clk(clk), .reset_n(reset_n), .start(st[2]), .ready(ready_v[2]),
        .head_x(hx_i), .head_y(hy_i), .dir(dir_i), .tail_x(tx_i), .tail_y(ty_i),
        .food_x(fx_i), .food_y(fy_i), .occupancy(occ2_i), .clear_over(clr[2]),
        .done(done_v[2]), .next_x(nx_v[2]), .next_y(ny_v[2]), .hit_wall(hw_v[2]),
        .hit_body(hb_v[2]), .hit_food(hf_v[2]), .collide(col_v[2]),
        .game_over(go_v[2]), .food_count(fc2));

    typedef struct {
        int         sel;
        bit         clr;
        logic [2:0] hx, hy, tx, ty, fx, fy;
        logic [1:0] dir;
        logic [63:0] occ;
        logic [2:0] nx, ny;
        bit         w, b, f, go;
        int         fc;
    } vec_t;

    typedef struct {
        logic [2:0] nx, ny;
        bit         w, b, f, go;
        int         fc;
        int         cyc;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    exp_t pexp [3];
    bit   pend [3];
    int   checks = 0, errors = 0;
    vec_t tbl[$];

    function automatic int fcv(int s);
        if (s == 0) return int'(fc0);
        if (s == 1) return int'(fc1);
        return int'(fc2);
    endfunction

    task automatic chk(input string name, input int s, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h expected=%0h (t=%0t)", name, s, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ob(input int x, input int y, input int gw);
        logic [63:0] r;
        r = '0;
        r[y*gw + gw - 1 - x] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input int sel, input bit c, input int hx, input int hy,
                                input logic [1:0] dir, input int tx, input int ty,
                                input int fx, input int fy, input logic [63:0] occ,
                                input int nx, input int ny, input bit w, input bit b,
                                input bit f, input bit go, input int fc);
        vec_t v;
        v.sel = sel;  v.clr = c;
        v.hx = 3'(hx);  v.hy = 3'(hy);  v.dir = dir;
        v.tx = 3'(tx);  v.ty = 3'(ty);  v.fx = 3'(fx);  v.fy = 3'(fy);
        v.occ = occ;
        v.nx = 3'(nx);  v.ny = 3'(ny);
        v.w = w;  v.b = b;  v.f = f;  v.go = go;  v.fc = fc;
        return v;
    endfunction

    task automatic push_exp(input int s, input exp_t e);
        case (s)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor: pop the expected record when done pulses; check status one cycle later.
    initial forever begin
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            if (pend[s]) begin
                chk("game_over", s, 64'(go_v[s]), 64'(pexp[s].go));
                chk("food_count", s, 64'(fcv(s)), 64'(pexp[s].fc));
                pend[s] = 1'b0;
            end
            if (done_v[s]) begin
                exp_t e;
                int   sz;
                sz = (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
                if (sz == 0) begin
                    chk("unexpected_done", s, 64'(1), 64'(0));
                end else begin
                    case (s)
                        0: e = q0.pop_front();
                        1: e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    chk("done_latency", s, 64'(cyc), 64'(e.cyc));
                    chk("next_x", s, 64'(nx_v[s]), 64'(e.nx));
                    chk("next_y", s, 64'(ny_v[s]), 64'(e.ny));
                    chk("hit_wall", s, 64'(hw_v[s]), 64'(e.w));
                    chk("hit_body", s, 64'(hb_v[s]), 64'(e.b));
                    chk("hit_food", s, 64'(hf_v[s]), 64'(e.f));
                    chk("collide", s, 64'(col_v[s]), 64'(e.w | e.b));
                    pexp[s] = e;
                    pend[s] = 1'b1;
                end
            end
        end
    end

    task automatic pulse_clear(input int s);
        @(negedge clk);
        clr[s] = 1'b1;
        @(negedge clk);
        clr[s] = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        hx_i = v.hx;  hy_i = v.hy;  dir_i = v.dir;
        tx_i = v.tx;  ty_i = v.ty;  fx_i = v.fx;  fy_i = v.fy;
        occ_i = v.occ;  occ2_i = v.occ[29:0];
        st[v.sel] = 1'b1;
        e.nx = v.nx;  e.ny = v.ny;  e.w = v.w;  e.b = v.b;  e.f = v.f;
        e.go = v.go;  e.fc = v.fc;  e.cyc = cyc + 3;
        push_exp(v.sel, e);
    endtask

    task automatic run(input vec_t v);
        if (v.clr) pulse_clear(v.sel);
        @(negedge clk);
        drive(v);
        @(negedge clk);
        st[v.sel] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // 8x8 walls
        tbl.push_back(mk(0,1, 7,3,R, 0,0, 0,0, 64'd0,        7,3, 1,0,0, 1,0));
        tbl.push_back(mk(0,1, 2,2,U, 2,1, 5,5, ob(2,1,8),    2,1, 0,0,0, 0,0));
        tbl.push_back(mk(0,1, 2,2,U, 2,1, 2,1, ob(2,1,8),    2,1, 0,1,1, 1,0));
        tbl.push_back(mk(0,1, 4,4,D, 0,0, 4,5, 64'd0,        4,5, 0,0,1, 0,1));
        tbl.push_back(mk(0,1, 0,0,U, 5,5, 0,0, ob(0,0,8),    0,0, 1,0,0, 1,0));
        tbl.push_back(mk(0,1, 0,5,L, 5,5, 6,6, 64'd0,        0,5, 1,0,0, 1,0));
        tbl.push_back(mk(0,1, 3,7,D, 5,5, 6,6, 64'd0,        3,7, 1,0,0, 1,0));
        tbl.push_back(mk(0,1, 3,3,L, 5,5, 6,6, ob(2,3,8),    2,3, 0,1,0, 1,0));
        tbl.push_back(mk(0,1, 3,3,R, 5,5, 6,6, ob(3,3,8)|ob(4,4,8), 4,3, 0,0,0, 0,0));
        tbl.push_back(mk(0,1, 6,6,D, 6,7, 0,0, ob(6,7,8),    6,7, 0,0,0, 0,0));
        tbl.push_back(mk(0,1, 1,1,R, 0,0, 2,1, 64'd0,        2,1, 0,0,1, 0,1));
        // 8x8 wrap
        tbl.push_back(mk(1,1, 7,3,R, 5,5, 1,1, 64'd0,        0,3, 0,0,0, 0,0));
        tbl.push_back(mk(1,1, 7,3,R, 5,5, 1,1, ob(0,3,8),    0,3, 0,1,0, 1,0));
        tbl.push_back(mk(1,1, 0,0,U, 5,5, 1,1, 64'd0,        0,7, 0,0,0, 0,0));
        tbl.push_back(mk(1,1, 0,0,L, 5,5, 1,1, 64'd0,        7,0, 0,0,0, 0,0));
        tbl.push_back(mk(1,1, 3,7,D, 5,5, 1,1, 64'd0,        3,0, 0,0,0, 0,0));
        tbl.push_back(mk(1,1, 7,3,R, 5,5, 0,3, 64'd0,        0,3, 0,0,1, 0,1));
        // 5x6 wrap, 2-bit counter
        tbl.push_back(mk(2,1, 4,2,R, 3,3, 1,1, 64'd0,        0,2, 0,0,0, 0,0));
        tbl.push_back(mk(2,1, 0,0,U, 3,3, 1,1, 64'd0,        0,5, 0,0,0, 0,0));
        tbl.push_back(mk(2,1, 2,5,D, 3,3, 1,1, 64'd0,        2,0, 0,0,0, 0,0));
        tbl.push_back(mk(2,1, 0,1,L, 3,3, 1,1, ob(4,1,5),    4,1, 0,1,0, 1,0));
        tbl.push_back(mk(2,1, 6,2,R, 3,3, 1,1, 64'd0,        6,2, 1,0,0, 1,0));
        tbl.push_back(mk(2,1, 2,6,U, 3,3, 1,1, 64'd0,        2,6, 1,0,0, 1,0));
        tbl.push_back(mk(2,1, 4,4,D, 0,0, 4,5, 64'd0,        4,5, 0,0,1, 0,1));
        tbl.push_back(mk(2,0, 4,4,D, 0,0, 4,5, 64'd0,        4,5, 0,0,1, 0,2));
        tbl.push_back(mk(2,0, 4,4,D, 0,0, 4,5, 64'd0,        4,5, 0,0,1, 0,3));
        tbl.push_back(mk(2,0, 4,4,D, 0,0, 4,5, 64'd0,        4,5, 0,0,1, 0,3));

        // Reset state
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk("rst_ready", s, 64'(ready_v[s]), 64'(1));
            chk("rst_done", s, 64'(done_v[s]), 64'(0));
            chk("rst_next", s, 64'({nx_v[s], ny_v[s]}), 64'(0));
            chk("rst_flags", s, 64'({hw_v[s], hb_v[s], hf_v[s], col_v[s], go_v[s]}), 64'(0));
            chk("rst_count", s, 64'(fcv(s)), 64'(0));
        end
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        // start held high across busy and game-over: exactly one done
        pulse_clear(0);
        @(negedge clk);
        drive(tbl[7]);
        repeat (10) @(negedge clk);
        st[0] = 1'b0;
        chk("hold_ready", 0, 64'(ready_v[0]), 64'(0));
        chk("hold_over", 0, 64'(go_v[0]), 64'(1));
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("clear_ready", 0, 64'(ready_v[0]), 64'(1));
        chk("clear_over", 0, 64'(go_v[0]), 64'(0));

        // clear_over in REPORT of a colliding move: set wins
        @(negedge clk);
        drive(tbl[0]);
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("set_wins", 0, 64'(go_v[0]), 64'(1));
        pulse_clear(0);

        // Reset during STEP: no done, outputs back to reset values
        @(negedge clk);
        hx_i = 3'd4;  hy_i = 3'd4;  dir_i = D;  fx_i = 3'd4;  fy_i = 3'd5;  occ_i = '0;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 0, 64'(ready_v[0]), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_done", 0, 64'(done_v[0]), 64'(0));
        chk("mid_rst_next", 0, 64'({nx_v[0], ny_v[0]}), 64'(0));
        chk("mid_rst_flags", 0, 64'({hw_v[0], hb_v[0], hf_v[0], go_v[0]}), 64'(0));
        chk("mid_rst_count", 0, 64'(fc0), 64'(0));
        chk("mid_rst_ready2", 0, 64'(ready_v[0]), 64'(1));

        repeat (3) @(negedge clk);
        chk("missing_done", 0, 64'(q0.size()), 64'(0));
        chk("missing_done", 1, 64'(q1.size()), 64'(0));
        chk("missing_done", 2, 64'(q2.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
